lfsr_rand_arbiter: RTL and testbench

Shares one internal Fibonacci LFSR random source among NUM_REQ requesters, using round-robin arbitration.
- Sequences the LFSR through a warm-up phase after reset or reseed.
- Serves one unique random word per grant.
- The LFSR steps only on warm-up or a grant, so no two grants ever return the same consecutive state.
- Sits between the PRNG datapath and client blocks (scramblers, test pattern generators, backoff timers).

---
 rtl/lfsr_rand_arbiter.sv | 111 +++++++++++
 tb/tb_lfsr_rand_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rand_arbiter.sv
// rtl/lfsr_rand_arbiter.sv - round-robin arbiter handing out unique Fibonacci LFSR words
// Warms the LFSR after reset/reseed, then serves one fresh word per single-cycle grant.
module lfsr_rand_arbiter #(
   parameter int               NUM_REQ       = 4,
   parameter int               WIDTH         = 8,
   parameter logic [WIDTH-1:0] SEED          = 8'h01,
   parameter logic [WIDTH-1:0] TAPS          = 8'hB8,
   parameter int               WARMUP_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               rnd_valid,
   output logic [WIDTH-1:0]   rnd_data,
   input  logic               seed_load,
   input  logic [WIDTH-1:0]   seed_value,
   output logic               busy
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] ST_WARMUP = 2'd0;
   localparam logic [1:0] ST_IDLE   = 2'd1;
   localparam logic [1:0] ST_SERVE  = 2'd2;

   localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] lfsr;
   logic [7:0]       warm_cnt;
   logic [PW-1:0]    rr_ptr;

   logic [WIDTH-1:0] lfsr_next;
   logic [WIDTH-1:0] load_val;
   logic [PW-1:0]    winner;
   logic [PW-1:0]    idx;
   logic             found;

   assign lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
   // A zero seed would lock the LFSR, so it is swapped for the reset seed.
   assign load_val  = (seed_value == '0) ? SEED : seed_value;
   assign busy      = (state == ST_WARMUP);

   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_WARMUP;
         lfsr      <= SEED;
         warm_cnt  <= '0;
         rr_ptr    <= PW'(NUM_REQ - 1);
         grant     <= '0;
         rnd_valid <= 1'b0;
         rnd_data  <= '0;
      end else begin
         grant     <= '0;
         rnd_valid <= 1'b0;
         case (state)
            ST_WARMUP: begin
               if (seed_load) begin
                  lfsr     <= load_val;
                  warm_cnt <= '0;
               end else begin
                  lfsr     <= lfsr_next;
                  warm_cnt <= warm_cnt + 8'd1;
                  if (warm_cnt == WARM_LAST)
                     state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (seed_load) begin
                  lfsr     <= load_val;
                  warm_cnt <= '0;
                  state    <= ST_WARMUP;
               end else if (found) begin
                  grant     <= NUM_REQ'(1) << winner;
                  rnd_valid <= 1'b1;
                  rnd_data  <= lfsr;
                  lfsr      <= lfsr_next;
                  rr_ptr    <= winner;
                  state     <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               // The grant already issued stands; a reseed here only affects future words.
               if (seed_load) begin
                  lfsr     <= load_val;
                  warm_cnt <= '0;
                  state    <= ST_WARMUP;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_WARMUP;
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// tb/tb_lfsr_rand_arbiter.sv - self-checking bench for lfsr_rand_arbiter
// Directed scenarios plus random traffic against a transaction-level reference model.
module tb_lfsr_rand_arbiter;

   localparam int N    = 4;
   localparam int WARM = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] grant;
   logic       rnd_valid;
   logic [7:0] rnd_data;
   logic       seed_load = 1'b0;
   logic [7:0] seed_value = '0;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int         m_warm;
   bit         m_serving;
   logic [7:0] m_lfsr;
   int         m_ptr;
   logic [3:0] m_grant;
   logic       m_valid;
   logic [7:0] m_data;

   lfsr_rand_arbiter dut (
      .clk(clk), .reset(reset), .req(req), .grant(grant), .rnd_valid(rnd_valid),
      .rnd_data(rnd_data), .seed_load(seed_load), .seed_value(seed_value), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
      int par;
      par = $countones(v & 8'hB8) % 2;
      return 8'((int'(v) * 2 + par) % 256);
   endfunction

   function automatic logic [7:0] seed_of(input logic [7:0] v);
      return (v == 8'h00) ? 8'h01 : v;
   endfunction

   task automatic m_reset();
      m_warm = WARM; m_serving = 0; m_lfsr = 8'h01; m_ptr = N - 1;
      m_grant = '0; m_valid = 1'b0; m_data = '0;
   endtask

   task automatic m_clock(input logic [3:0] r, input logic sl, input logic [7:0] sv);
      int w;
      m_grant = '0;
      m_valid = 1'b0;
      if (m_warm > 0) begin
         if (sl) begin
            m_lfsr = seed_of(sv); m_warm = WARM;
         end else begin
            m_lfsr = lfsr_adv(m_lfsr); m_warm--;
         end
      end else if (m_serving) begin
         m_serving = 0;
         if (sl) begin
            m_lfsr = seed_of(sv); m_warm = WARM;
         end
      end else if (sl) begin
         m_lfsr = seed_of(sv); m_warm = WARM;
      end else if (r != 0) begin
         w = -1;
         for (int k = 1; k <= N; k++)
            if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         m_grant = 4'(1 << w);
         m_valid = 1'b1;
         m_data = m_lfsr;
         m_lfsr = lfsr_adv(m_lfsr);
         m_ptr = w;
         m_serving = 1;
      end
   endtask

   task automatic check_outputs();
      chk("grant", grant, m_grant);
      chk("rnd_valid", rnd_valid, m_valid);
      chk("rnd_data", rnd_data, m_data);
      chk("busy", busy, m_warm > 0);
      chk("lfsr", dut.lfsr, m_lfsr);
   endtask

   task automatic cycle();
      logic [3:0] r;
      logic       sl;
      logic [7:0] sv;
      r = req; sl = seed_load; sv = seed_value;
      @(posedge clk);
      m_clock(r, sl, sv);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      req = '0; seed_load = 1'b0; seed_value = '0;
      reset = 1'b1;
      m_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_outputs();
   endtask

   logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [7:0] exp_d [5] = '{8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};

   initial begin
      // 1: reset release, warm-up
      do_reset();
      chk("t1_busy_start", busy, 1);
      for (int i = 0; i < WARM; i++) cycle();
      chk("t1_busy_end", busy, 0);
      chk("t1_lfsr", dut.lfsr, 8'h11);
      cycle();
      chk("t1_no_grant", grant, 0);

      // 2: single request, then a second one
      req = 4'b0001; cycle();
      chk("t2_grant", grant, 4'b0001);
      chk("t2_data1", rnd_data, 8'h11);
      req = '0; cycle();
      req = 4'b0001; cycle();
      chk("t2_data2", rnd_data, 8'h23);
      req = '0; cycle();

      // 3: round robin with all requests held
      do_reset();
      for (int i = 0; i < WARM; i++) cycle();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t3_grant", grant, exp_g[i]);
         chk("t3_data", rnd_data, exp_d[i]);
         cycle();
         chk("t3_gap", grant, 0);
      end
      req = '0; cycle();

      // 4: zero seed load in IDLE
      seed_load = 1'b1; seed_value = 8'h00; cycle();
      seed_load = 1'b0;
      chk("t4_busy", busy, 1);
      for (int i = 0; i < WARM; i++) cycle();
      chk("t4_idle", busy, 0);
      req = 4'b0001; cycle();
      chk("t4_data", rnd_data, 8'h11);

      // 5: reseed coincident with a grant cycle
      req = '0; cycle();
      req = 4'b0001; cycle();
      chk("t5_grant", grant, 4'b0001);
      chk("t5_data_pre", rnd_data, 8'h23);
      req = '0; seed_load = 1'b1; seed_value = 8'h80; cycle();
      seed_load = 1'b0;
      chk("t5_busy", busy, 1);
      for (int i = 0; i < WARM; i++) begin
         cycle();
         chk("t5_nonzero", dut.lfsr != 8'h00, 1);
      end
      req = 4'b0001; cycle();
      chk("t5_data_post", rnd_data, 8'h08);
      req = '0; cycle();

      // 6: reset during a grant cycle
      req = 4'b0010; cycle();
      chk("t6_grant_before", grant, 4'b0010);
      reset = 1'b1;
      #1;
      chk("t6_grant_drop", grant, 0);
      chk("t6_valid_drop", rnd_valid, 0);
      chk("t6_busy", busy, 1);
      m_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      req = '0;
      for (int i = 0; i < WARM; i++) cycle();
      req = 4'b1111; cycle();
      chk("t6_grant_after", grant, 4'b0001);
      chk("t6_data_after", rnd_data, 8'h11);
      req = '0; cycle();

      // random traffic
      for (int i = 0; i < 500; i++) begin
         req = 4'($urandom);
         seed_load = ($urandom_range(0, 19) == 0);
         seed_value = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
